multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM for the MIPS-subset datapath. It replaces single-cycle decode with an IF/ID/EXE/MEM/WB sequencer, so one ALU and one unified single-port memory are reused across cycles. Memory accesses wait on a ready handshake. The block sits between the instruction register fields (op, func), the ALU zero flag, and every datapath mux select and write enable.

## Interface
- Parameters: none.
- `clk` in 1: rising-edge clock.
- `clrn` in 1: asynchronous, active-low reset.
- `op` in 6: IR[31:26], valid from ID onward.
- `func` in 6: IR[5:0].
- `z` in 1: ALU zero flag, sampled in EXE.
- `mem_ready` in 1: memory has completed the current read or write this cycle.
- `wpc`, `wir`, `wreg`, `wmem` out 1 each: PC, IR, register-file and memory write strobes.
- `iord` out 1: memory address select; 0 = PC, 1 = ALU-out register.
- `regrt` out 1: destination select; 1 = rt, 0 = rd.
- `jal` out 1: destination forced to $31, write data = PC.
- `m2reg` out 1: register write data from memory.
- `shift` out 1: ALU A input = sa field.
- `alusrca` out 1: ALU A input; 0 = PC, 1 = rs.
- `alusrcb` out 2: ALU B input; 00 = rt, 01 = const 4, 10 = extended imm, 11 = sext(imm)<<2.
- `sext` out 1: sign-extend (1) or zero-extend (0) imm.
- `aluc` out 4: ALU function. Encoding: add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110, sll 0011, srl 0111, sra 1111.
- `pcsrc` out 2: next-PC select; 00 = ALU, 01 = branch target, 10 = rs, 11 = jump.
- `retire` out 1: one-cycle pulse on the final cycle of each instruction.
- `state` out 3: current state, for debug.

## Operation
- States and encoding: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5 (HALT exists only with the macro).
- All outputs are combinational from state, op, func, z and mem_ready. Every unlisted strobe is 0 and every unlisted select is 0.
- **IF** (`iord`=0): `alusrca`=0, `alusrcb`=01, `aluc`=add, `pcsrc`=00.
  - `mem_ready`=0: stay in IF, no strobes.
  - `mem_ready`=1: `wir`=1 and `wpc`=1 in the same cycle, then go to ID.
- **ID**: ALU computes the branch target (`alusrca`=0, `alusrcb`=11, add) into the ALU-out register.
  - j: `wpc`=1, `pcsrc`=11. jr: `wpc`=1, `pcsrc`=10.
  - jal: `wpc`=1, `pcsrc`=11, `wreg`=1, `jal`=1.
  - All three assert `retire` and go to IF. Every other instruction goes to EXE.
- **EXE**: `alusrca`=1.
  - R-type: `alusrcb`=00; `shift`=1 for sll/srl/sra.
  - Immediate and memory instructions: `alusrcb`=10. `sext`=1 for addi, xori, lw, sw; `sext`=0 for andi, ori; lui ignores the extension.
  - beq/bne: `aluc`=sub, `alusrcb`=00. `wpc` = z (beq) or !z (bne) with `pcsrc`=01; `retire` asserted; go to IF.
  - lw/sw go to MEM. All others go to WB.
- **MEM** (`iord`=1):
  - sw: `wmem`=1 is held every cycle until `mem_ready`. On `mem_ready`: `retire`, go to IF.
  - lw: waits for `mem_ready`, then goes to WB.
- **WB**: `wreg`=1, `retire`=1, go to IF.
  - `m2reg`=1 for lw.
  - `regrt`=1 for I-type, 0 for R-type.
- Retire latency with `mem_ready` tied high: j/jr/jal 2 cycles, branches 3, R/I-type ALU 4, sw 4, lw 5.
- Unrecognised op, or unrecognised func under op=0: treated as NOP; no strobes, `retire` in ID, go to IF.

## Timing
- While `clrn`=0: state=IF and all strobes (`wpc`, `wir`, `wreg`, `wmem`, `retire`) are forced to 0 combinationally. `state`=0; all selects = 0.
- The first fetch is sampled on the first rising edge after `clrn` deasserts.
- Reset mid-instruction aborts immediately; no partial write is issued after `clrn` falls.
- A `mem_ready` pulse outside IF or MEM is ignored.
- `mem_ready` high on the first cycle of IF or MEM gives zero wait states.
- `z` is sampled only in EXE of a branch; a glitch in any other state has no effect.

## Configuration
- `MCTRL_ILLEGAL_TRAP_EN`:
  - Defined: an unrecognised op or func moves ID to HALT. HALT asserts no strobes, holds `state`=5, and is left only by reset. An `illegal` output port (1 bit) is added and is high in HALT.
  - Undefined: the NOP behaviour above applies; there is no HALT state and no `illegal` port.

## Structure
- Package `mc_pkg` holds: state encoding constants; opcode and func constants; `aluc` codes; `alusrcb` and `pcsrc` encodings; the instruction-class enum (RTYPE, SHIFT, ALUI, LW, SW, BRANCH, JUMP, JR, JAL, ILLEGAL).
- Sub-module `mc_decode` is purely combinational: op, func → class, `aluc`, `sext`. The FSM instantiates it once.

## Test plan
- **Reset and fetch**: `clrn` low 3 cycles → all strobes 0, `state`=0. Release with `mem_ready`=1 → `wir`=`wpc`=1 on the first cycle.
- **add with fetch stall**: add $3,$1,$2 with `mem_ready` low for 2 IF cycles → `retire` on cycle 6; `wreg`=1 and `regrt`=0 in WB.
- **lw/sw**: lw with 3 MEM wait cycles → `m2reg`=1, `wreg` in WB, total 8 cycles. sw → `wmem` high in every MEM cycle through the `mem_ready` cycle, then IF.
- **Branches**: beq with z=1 → EXE `wpc`=1, `pcsrc`=01. beq with z=0 → `wpc`=0. bne with z=0 → `wpc`=1.
- **jal**: jal → ID `wpc`=1, `pcsrc`=11, `wreg`=1, `jal`=1, `retire`=1, then IF.
- **Illegal opcode and reset abort**: op=6'b111111 → NOP retire without the macro; with the macro, HALT and `illegal`=1 until reset. Assert `clrn` during MEM of sw → `wmem` drops the same cycle.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: states, opcodes,
// func codes, ALU operations, datapath select values and instruction classes.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EXE  = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] PC_ALU  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_RS   = 2'b10;
  localparam logic [1:0] PC_JUMP = 2'b11;

  typedef enum logic [3:0] {
    RTYPE, SHIFT, ALUI, LW, SW, BRANCH, JUMP, JR, JAL, ILLEGAL
  } iclass_e;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decode: op/func to instruction class, ALU function
// and immediate extension mode.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output iclass_e    cls,
  output logic [3:0] aluc,
  output logic       sext
);

  always_comb begin
    cls  = ILLEGAL;
    aluc = ALUC_ADD;
    sext = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADD:  begin cls = RTYPE; aluc = ALUC_ADD; end
          FN_SUB:  begin cls = RTYPE; aluc = ALUC_SUB; end
          FN_AND:  begin cls = RTYPE; aluc = ALUC_AND; end
          FN_OR:   begin cls = RTYPE; aluc = ALUC_OR;  end
          FN_XOR:  begin cls = RTYPE; aluc = ALUC_XOR; end
          FN_SLL:  begin cls = SHIFT; aluc = ALUC_SLL; end
          FN_SRL:  begin cls = SHIFT; aluc = ALUC_SRL; end
          FN_SRA:  begin cls = SHIFT; aluc = ALUC_SRA; end
          FN_JR:   cls = JR;
          default: cls = ILLEGAL;
        endcase
      end
      OP_ADDI: begin cls = ALUI;   aluc = ALUC_ADD; sext = 1'b1; end
      OP_ANDI: begin cls = ALUI;   aluc = ALUC_AND; end
      OP_ORI:  begin cls = ALUI;   aluc = ALUC_OR;  end
      OP_XORI: begin cls = ALUI;   aluc = ALUC_XOR; sext = 1'b1; end
      OP_LUI:  begin cls = ALUI;   aluc = ALUC_LUI; end
      OP_LW:   begin cls = LW;     aluc = ALUC_ADD; sext = 1'b1; end
      OP_SW:   begin cls = SW;     aluc = ALUC_ADD; sext = 1'b1; end
      OP_BEQ:  begin cls = BRANCH; aluc = ALUC_SUB; end
      OP_BNE:  begin cls = BRANCH; aluc = ALUC_SUB; end
      OP_J:    cls = JUMP;
      OP_JAL:  cls = JAL;
      default: cls = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// IF/ID/EXE/MEM/WB sequencer for the shared-ALU, single-port-memory datapath.
// Define MCTRL_ILLEGAL_TRAP_EN to trap unrecognised instructions in HALT.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       clrn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_ready,
  output logic       wpc,
  output logic       wir,
  output logic       wreg,
  output logic       wmem,
  output logic       iord,
  output logic       regrt,
  output logic       jal,
  output logic       m2reg,
  output logic       shift,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       sext,
  output logic [3:0] aluc,
  output logic [1:0] pcsrc,
  output logic       retire,
  output logic [2:0] state
`ifdef MCTRL_ILLEGAL_TRAP_EN
  ,
  output logic       illegal
`endif
);

  state_e     state_q, state_d;
  iclass_e    cls;
  logic [3:0] dec_aluc;
  logic       dec_sext;

  mc_decode u_decode (
    .op   (op),
    .func (func),
    .cls  (cls),
    .aluc (dec_aluc),
    .sext (dec_sext)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= ST_IF;
    else       state_q <= state_d;
  end

  // Gating on clrn keeps every strobe and select low the moment reset asserts.
  always_comb begin
    state_d = state_q;
    wpc     = 1'b0;
    wir     = 1'b0;
    wreg    = 1'b0;
    wmem    = 1'b0;
    iord    = 1'b0;
    regrt   = 1'b0;
    jal     = 1'b0;
    m2reg   = 1'b0;
    shift   = 1'b0;
    alusrca = 1'b0;
    alusrcb = SRCB_RT;
    sext    = 1'b0;
    aluc    = ALUC_ADD;
    pcsrc   = PC_ALU;
    retire  = 1'b0;
    if (clrn) begin
      case (state_q)
        ST_IF: begin
          alusrcb = SRCB_FOUR;
          if (mem_ready) begin
            wir     = 1'b1;
            wpc     = 1'b1;
            state_d = ST_ID;
          end
        end
        ST_ID: begin
          alusrcb = SRCB_BR;
          case (cls)
            JUMP: begin
              wpc = 1'b1; pcsrc = PC_JUMP; retire = 1'b1; state_d = ST_IF;
            end
            JR: begin
              wpc = 1'b1; pcsrc = PC_RS; retire = 1'b1; state_d = ST_IF;
            end
            JAL: begin
              wpc = 1'b1; pcsrc = PC_JUMP; wreg = 1'b1; jal = 1'b1;
              retire = 1'b1; state_d = ST_IF;
            end
            ILLEGAL: begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
              state_d = ST_HALT;
`else
              retire  = 1'b1;
              state_d = ST_IF;
`endif
            end
            default: state_d = ST_EXE;
          endcase
        end
        ST_EXE: begin
          alusrca = 1'b1;
          aluc    = dec_aluc;
          case (cls)
            RTYPE: state_d = ST_WB;
            SHIFT: begin shift = 1'b1; state_d = ST_WB; end
            BRANCH: begin
              pcsrc   = PC_BR;
              wpc     = (op == OP_BNE) ? !z : z;
              retire  = 1'b1;
              state_d = ST_IF;
            end
            LW, SW: begin
              alusrcb = SRCB_IMM; sext = dec_sext; state_d = ST_MEM;
            end
            default: begin
              alusrcb = SRCB_IMM; sext = dec_sext; state_d = ST_WB;
            end
          endcase
        end
        ST_MEM: begin
          iord = 1'b1;
          if (cls == SW) begin
            wmem = 1'b1;
            if (mem_ready) begin
              retire  = 1'b1;
              state_d = ST_IF;
            end
          end else if (mem_ready) begin
            state_d = ST_WB;
          end
        end
        ST_WB: begin
          wreg    = 1'b1;
          retire  = 1'b1;
          m2reg   = (cls == LW);
          regrt   = (cls == ALUI) || (cls == LW);
          state_d = ST_IF;
        end
`ifdef MCTRL_ILLEGAL_TRAP_EN
        ST_HALT: state_d = ST_HALT;
`endif
        default: state_d = ST_IF;
      endcase
    end
  end

  assign state = state_q;
`ifdef MCTRL_ILLEGAL_TRAP_EN
  assign illegal = (state_q == ST_HALT);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed plus randomized bench for multicycle_ctrl; expected outputs come from
// a per-instruction phase schedule built from the instruction's behaviour.
module tb_multicycle_ctrl;

  localparam int P_IF = 0, P_ID = 1, P_EXE = 2, P_MEM = 3, P_WB = 4, P_HALT = 5;
  localparam int K_R = 0, K_SH = 1, K_I = 2, K_LW = 3, K_SW = 4, K_BEQ = 5,
                 K_BNE = 6, K_J = 7, K_JR = 8, K_JAL = 9, K_NOP = 10;
  localparam int NI = 22;

  logic       clk = 1'b0;
  logic       clrn;
  logic [5:0] op, func;
  logic       z, mem_ready;
  logic       wpc, wir, wreg, wmem, iord, regrt, jal, m2reg, shift, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       sext, retire;
  logic [3:0] aluc;
  logic [2:0] state;
`ifdef MCTRL_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .clrn(clrn), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
    .wpc(wpc), .wir(wir), .wreg(wreg), .wmem(wmem), .iord(iord), .regrt(regrt),
    .jal(jal), .m2reg(m2reg), .shift(shift), .alusrca(alusrca), .alusrcb(alusrcb),
    .sext(sext), .aluc(aluc), .pcsrc(pcsrc), .retire(retire), .state(state)
`ifdef MCTRL_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  logic [22:0] obs;
  assign obs = {wpc, wir, wreg, wmem, iord, regrt, jal, m2reg, shift, alusrca,
                alusrcb, sext, aluc, pcsrc, retire, state};

  task automatic check(input string tag, input logic [22:0] o, input logic [22:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Instruction table: op, func, behaviour kind, ALU code, extension mode.
  function automatic void get_instr(input int i, output logic [5:0] o, output logic [5:0] f,
                                    output int k, output logic [3:0] a, output logic s);
    o = 6'd0; f = 6'd0; k = K_NOP; a = 4'b0000; s = 1'b0;
    case (i)
      0:  begin f = 6'b100000; k = K_R;  a = 4'b0000; end
      1:  begin f = 6'b100010; k = K_R;  a = 4'b0100; end
      2:  begin f = 6'b100100; k = K_R;  a = 4'b0001; end
      3:  begin f = 6'b100101; k = K_R;  a = 4'b0101; end
      4:  begin f = 6'b100110; k = K_R;  a = 4'b0010; end
      5:  begin f = 6'b000000; k = K_SH; a = 4'b0011; end
      6:  begin f = 6'b000010; k = K_SH; a = 4'b0111; end
      7:  begin f = 6'b000011; k = K_SH; a = 4'b1111; end
      8:  begin f = 6'b001000; k = K_JR; end
      9:  begin o = 6'b001000; k = K_I;  a = 4'b0000; s = 1'b1; end
      10: begin o = 6'b001100; k = K_I;  a = 4'b0001; end
      11: begin o = 6'b001101; k = K_I;  a = 4'b0101; end
      12: begin o = 6'b001110; k = K_I;  a = 4'b0010; s = 1'b1; end
      13: begin o = 6'b001111; k = K_I;  a = 4'b0110; end
      14: begin o = 6'b100011; k = K_LW; a = 4'b0000; s = 1'b1; end
      15: begin o = 6'b101011; k = K_SW; a = 4'b0000; s = 1'b1; end
      16: begin o = 6'b000100; k = K_BEQ; a = 4'b0100; end
      17: begin o = 6'b000101; k = K_BNE; a = 4'b0100; end
      18: begin o = 6'b000010; k = K_J; end
      19: begin o = 6'b000011; k = K_JAL; end
      20: begin o = 6'b111111; k = K_NOP; end
      default: begin o = 6'b000000; f = 6'b111111; k = K_NOP; end
    endcase
  endfunction

  function automatic logic [22:0] exp_vec(input int ph, input int k, input logic [3:0] a,
                                          input logic s, input logic zb, input logic mr);
    logic e_wpc = 0, e_wir = 0, e_wreg = 0, e_wmem = 0, e_iord = 0, e_rgt = 0;
    logic e_jal = 0, e_m2r = 0, e_sh = 0, e_asa = 0, e_sx = 0, e_ret = 0;
    logic [1:0] e_srcb = 2'b00, e_pcs = 2'b00;
    logic [3:0] e_al = 4'b0000;
    logic [2:0] e_st;
    e_st = 3'(ph);
    case (ph)
      P_IF: begin
        e_srcb = 2'b01;
        if (mr) begin e_wir = 1; e_wpc = 1; end
      end
      P_ID: begin
        e_srcb = 2'b11;
        if (k == K_J)   begin e_wpc = 1; e_pcs = 2'b11; e_ret = 1; end
        if (k == K_JR)  begin e_wpc = 1; e_pcs = 2'b10; e_ret = 1; end
        if (k == K_JAL) begin e_wpc = 1; e_pcs = 2'b11; e_wreg = 1; e_jal = 1; e_ret = 1; end
`ifndef MCTRL_ILLEGAL_TRAP_EN
        if (k == K_NOP) e_ret = 1;
`endif
      end
      P_EXE: begin
        e_asa = 1; e_al = a;
        if (k == K_BEQ || k == K_BNE) begin
          e_pcs = 2'b01; e_ret = 1; e_wpc = (k == K_BEQ) ? zb : !zb;
        end else if (k == K_SH) begin
          e_sh = 1;
        end else if (k != K_R) begin
          e_srcb = 2'b10; e_sx = s;
        end
      end
      P_MEM: begin
        e_iord = 1;
        if (k == K_SW) begin e_wmem = 1; e_ret = mr; end
      end
      P_WB: begin
        e_wreg = 1; e_ret = 1; e_m2r = (k == K_LW); e_rgt = (k == K_I || k == K_LW);
      end
      default: ;
    endcase
    return {e_wpc, e_wir, e_wreg, e_wmem, e_iord, e_rgt, e_jal, e_m2r, e_sh, e_asa,
            e_srcb, e_sx, e_al, e_pcs, e_ret, e_st};
  endfunction

  // Runs one instruction from its first IF cycle; abort_at >= 0 drops clrn in that cycle.
  task automatic run_instr(input int idx, input int wf, input int wm, input logic zb,
                           input int abort_at);
    logic [5:0] o, f;
    logic [3:0] a;
    logic       s;
    int         k;
    int         ph[$];
    logic       mrq[$];
    bit         halted;
    string      tag;
    get_instr(idx, o, f, k, a, s);
    halted = 0;
    for (int i = 0; i < wf; i++) begin ph.push_back(P_IF); mrq.push_back(1'b0); end
    ph.push_back(P_IF); mrq.push_back(1'b1);
    ph.push_back(P_ID); mrq.push_back(1'($urandom_range(0, 1)));
    if (k == K_NOP) begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
      for (int i = 0; i < 3; i++) begin ph.push_back(P_HALT); mrq.push_back(1'($urandom_range(0, 1))); end
      halted = 1;
`endif
    end else if (k != K_J && k != K_JR && k != K_JAL) begin
      ph.push_back(P_EXE); mrq.push_back(1'($urandom_range(0, 1)));
      if (k == K_LW || k == K_SW) begin
        for (int i = 0; i < wm; i++) begin ph.push_back(P_MEM); mrq.push_back(1'b0); end
        ph.push_back(P_MEM); mrq.push_back(1'b1);
      end
      if (k != K_SW && k != K_BEQ && k != K_BNE) begin
        ph.push_back(P_WB); mrq.push_back(1'($urandom_range(0, 1)));
      end
    end
    for (int c = 0; c < ph.size(); c++) begin
      if (ph[c] == P_IF) begin op = 6'($urandom); func = 6'($urandom); end
      else begin op = o; func = f; end
      z = (ph[c] == P_EXE) ? zb : 1'($urandom_range(0, 1));
      mem_ready = mrq[c];
      @(negedge clk);
      tag = $sformatf("instr%0d cyc%0d phase%0d", idx, c, ph[c]);
      check(tag, obs, exp_vec(ph[c], k, a, s, zb, mrq[c]));
`ifdef MCTRL_ILLEGAL_TRAP_EN
      check({tag, " illegal"}, {22'd0, illegal}, {22'd0, (ph[c] == P_HALT)});
`endif
      if (c == abort_at) begin
        #2 clrn = 1'b0;
        #1 check({tag, " abort"}, obs, 23'd0);
        @(posedge clk); #1;
        check({tag, " abort held"}, obs, 23'd0);
        clrn = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    if (halted) begin
      clrn = 1'b0;
      @(posedge clk); #1;
      clrn = 1'b1;
    end
  endtask

  initial begin
    clrn = 1'b0; mem_ready = 1'b1; z = 1'b0; op = 6'd0; func = 6'd0;
    #1;
    for (int i = 0; i < 3; i++) begin
      op = 6'($urandom); func = 6'($urandom);
      @(negedge clk);
      check($sformatf("reset cyc%0d", i), obs, 23'd0);
      @(posedge clk); #1;
    end
    clrn = 1'b1;
    run_instr(0, 0, 0, 1'b0, -1);   // add, first fetch right after reset
    run_instr(0, 2, 0, 1'b0, -1);   // add with two fetch stall cycles
    run_instr(14, 0, 3, 1'b0, -1);  // lw with three memory wait states
    run_instr(15, 0, 2, 1'b0, -1);  // sw held across wait states
    run_instr(15, 0, 0, 1'b1, -1);  // sw, zero wait states
    run_instr(16, 0, 0, 1'b1, -1);  // beq taken
    run_instr(16, 0, 0, 1'b0, -1);  // beq not taken
    run_instr(17, 0, 0, 1'b0, -1);  // bne taken
    run_instr(17, 1, 0, 1'b1, -1);  // bne not taken
    run_instr(19, 0, 0, 1'b0, -1);  // jal
    run_instr(18, 0, 0, 1'b0, -1);  // j
    run_instr(8, 0, 0, 1'b0, -1);   // jr
    run_instr(20, 0, 0, 1'b0, -1);  // unrecognised op
    run_instr(21, 0, 0, 1'b0, -1);  // unrecognised func
    run_instr(15, 0, 3, 1'b0, 4);   // reset during second MEM cycle of sw
    for (int n = 0; n < 80; n++)
      run_instr(int'($urandom_range(0, NI - 1)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
    run_instr(13, 0, 0, 1'b0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
